// File: rtl/pipelined_regfile_3stage.sv
// 3-stage fetch/decode -> execute -> memory/writeback CPU core with 16x16 regfile and S3->S2 forwarding.
// Latency: result written 2 cycles after fetch; no backpressure, never stalls (taken BEQ/JR squash one slot).
module pipelined_regfile_3stage #(
    parameter int                   ISIZE  = 16,
    parameter logic [256*ISIZE-1:0] IMAGE0 = '0,
    parameter logic [256*ISIZE-1:0] IMAGE1 = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fileid,
    output logic [ISIZE-1:0] PCOUT,
    output logic [ISIZE-1:0] PCIN,
    output logic [ISIZE-1:0] INST,
    output logic [ISIZE-1:0] rdata1,
    output logic [ISIZE-1:0] rdata2,
    output logic             regDst,
    output logic             jump,
    output logic [ISIZE-1:0] PC_ID_EXE,
    output logic [ISIZE-1:0] rdata1_ID_EXE,
    output logic [ISIZE-1:0] rdata2_ID_EXE,
    output logic [ISIZE-1:0] imm_ID_EXE,
    output logic [2:0]       aluop_ID_EXE,
    output logic             alusrc_ID_EXE,
    output logic             branch_ID_EXE,
    output logic             jr,
    output logic [3:0]       waddr_out_ID_EXE,
    output logic [ISIZE-1:0] rdata2_imm_ID_EXE,
    output logic [ISIZE-1:0] aluout,
    output logic             zero,
    output logic [ISIZE-1:0] aluout_EXE_DM,
    output logic [ISIZE-1:0] rdata2_EXE_DM,
    output logic [3:0]       waddr_out_EXE_DM,
    output logic             memWrite_EXE_DM,
    output logic             memRead_EXE_DM,
    output logic             memToReg_WB,
    output logic             wen_DM_WB,
    output logic             jal_out,
    output logic [ISIZE-1:0] readMem,
    output logic [ISIZE-1:0] aluout_DM,
    output logic [ISIZE-1:0] res,
    output logic [ISIZE-1:0] aluout_WB,
    output logic [3:0]       waddr_jal,
    output logic [ISIZE-1:0] aluout_jal
);
    localparam logic [ISIZE-1:0] ONE = ISIZE'(1);

    logic [ISIZE-1:0] r_regs [16];
    logic [ISIZE-1:0] r_dmem [256];
    logic [3:0]       r_raddr1_ID_EXE, r_raddr2_ID_EXE;
    logic             r_memWrite_ID_EXE, r_memRead_ID_EXE, r_memToReg_ID_EXE;
    logic             r_wen_ID_EXE, r_jal_ID_EXE;

    logic [3:0]       w_op, w_rd, w_rs, w_rt, w_raddr2, w_waddr;
    logic [2:0]       w_aluop;
    logic             w_alusrc, w_wen;
    logic [ISIZE-1:0] w_imm, w_fwd1, w_fwd2, w_alu, w_target;
    logic             w_redirect;

    // ---------------- S1: fetch, decode, register read ----------------
    assign INST = fileid ? IMAGE1[int'(PCOUT[7:0])*ISIZE +: ISIZE]
                         : IMAGE0[int'(PCOUT[7:0])*ISIZE +: ISIZE];
    assign w_op  = INST[15:12];
    assign w_rd  = INST[11:8];
    assign w_rs  = INST[7:4];
    assign w_rt  = INST[3:0];
    assign w_imm = {{(ISIZE-4){INST[3]}}, INST[3:0]};

    // Second read port takes rt for R-type ops, rd for BEQ compare and SW data.
    assign w_raddr2 = (w_op <= 4'd5) ? w_rt : w_rd;
    assign regDst   = (w_op <= 4'd7) || (w_op == 4'hB);
    assign jump     = (w_op == 4'hA) || (w_op == 4'hB);
    assign w_waddr  = (w_op == 4'hB) ? 4'd15 : (regDst ? w_rd : 4'd0);
    assign w_wen    = regDst && (w_waddr != 4'd0);
    assign w_alusrc = (w_op == 4'd6) || (w_op == 4'd7) || (w_op == 4'd8);
    assign w_aluop  = (w_op <= 4'd5) ? w_op[2:0] : ((w_op == 4'd9) ? 3'd1 : 3'd0);

    assign rdata1 = (w_rs == 4'd0) ? '0 :
                    (wen_DM_WB && waddr_jal == w_rs) ? res : r_regs[w_rs];
    assign rdata2 = (w_raddr2 == 4'd0) ? '0 :
                    (wen_DM_WB && waddr_jal == w_raddr2) ? res : r_regs[w_raddr2];

    // ---------------- S2: execute ----------------
    assign w_fwd1 = (wen_DM_WB && waddr_jal == r_raddr1_ID_EXE) ? res : rdata1_ID_EXE;
    assign w_fwd2 = (wen_DM_WB && waddr_jal == r_raddr2_ID_EXE) ? res : rdata2_ID_EXE;
    assign rdata2_imm_ID_EXE = alusrc_ID_EXE ? imm_ID_EXE : w_fwd2;

    always_comb begin
        w_alu = '0;
        case (aluop_ID_EXE)
            3'd0: w_alu = w_fwd1 + rdata2_imm_ID_EXE;
            3'd1: w_alu = w_fwd1 - rdata2_imm_ID_EXE;
            3'd2: w_alu = w_fwd1 & rdata2_imm_ID_EXE;
            3'd3: w_alu = w_fwd1 | rdata2_imm_ID_EXE;
            3'd4: w_alu = w_fwd1 ^ rdata2_imm_ID_EXE;
            3'd5: w_alu = {{(ISIZE-1){1'b0}}, ($signed(w_fwd1) < $signed(rdata2_imm_ID_EXE))};
            default: w_alu = '0;
        endcase
    end

    assign aluout     = r_jal_ID_EXE ? (PC_ID_EXE + ONE) : w_alu;
    assign zero       = (aluout == '0);
    assign w_redirect = (branch_ID_EXE && zero) || jr;
    assign w_target   = jr ? w_fwd1 : (PC_ID_EXE + ONE + imm_ID_EXE);
    assign PCIN       = w_redirect ? w_target :
                        jump       ? {PCOUT[ISIZE-1:12], INST[11:0]} : PCOUT + ONE;

    // ---------------- S3: data memory and writeback ----------------
    assign readMem    = r_dmem[aluout_EXE_DM[7:0]];
    assign aluout_DM  = aluout_EXE_DM;
    assign res        = memToReg_WB ? readMem : aluout_DM;
    assign aluout_WB  = res;
    assign waddr_jal  = waddr_out_EXE_DM;
    assign aluout_jal = res;

    always_ff @(posedge clk) begin
        if (!rst) PCOUT <= '0;
        else      PCOUT <= PCIN;
    end

    // A resolved S2 redirect turns the S1 instruction into a bubble.
    always_ff @(posedge clk) begin
        if (!rst || w_redirect) begin
            PC_ID_EXE         <= '0;
            rdata1_ID_EXE     <= '0;
            rdata2_ID_EXE     <= '0;
            imm_ID_EXE        <= '0;
            aluop_ID_EXE      <= '0;
            alusrc_ID_EXE     <= 1'b0;
            branch_ID_EXE     <= 1'b0;
            jr                <= 1'b0;
            waddr_out_ID_EXE  <= '0;
            r_raddr1_ID_EXE   <= '0;
            r_raddr2_ID_EXE   <= '0;
            r_memWrite_ID_EXE <= 1'b0;
            r_memRead_ID_EXE  <= 1'b0;
            r_memToReg_ID_EXE <= 1'b0;
            r_wen_ID_EXE      <= 1'b0;
            r_jal_ID_EXE      <= 1'b0;
        end else begin
            PC_ID_EXE         <= PCOUT;
            rdata1_ID_EXE     <= rdata1;
            rdata2_ID_EXE     <= rdata2;
            imm_ID_EXE        <= w_imm;
            aluop_ID_EXE      <= w_aluop;
            alusrc_ID_EXE     <= w_alusrc;
            branch_ID_EXE     <= (w_op == 4'd9);
            jr                <= (w_op == 4'hC);
            waddr_out_ID_EXE  <= w_waddr;
            r_raddr1_ID_EXE   <= w_rs;
            r_raddr2_ID_EXE   <= w_raddr2;
            r_memWrite_ID_EXE <= (w_op == 4'd8);
            r_memRead_ID_EXE  <= (w_op == 4'd7);
            r_memToReg_ID_EXE <= (w_op == 4'd7);
            r_wen_ID_EXE      <= w_wen;
            r_jal_ID_EXE      <= (w_op == 4'hB);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            aluout_EXE_DM    <= '0;
            rdata2_EXE_DM    <= '0;
            waddr_out_EXE_DM <= '0;
            memWrite_EXE_DM  <= 1'b0;
            memRead_EXE_DM   <= 1'b0;
            memToReg_WB      <= 1'b0;
            wen_DM_WB        <= 1'b0;
            jal_out          <= 1'b0;
        end else begin
            aluout_EXE_DM    <= aluout;
            rdata2_EXE_DM    <= w_fwd2;
            waddr_out_EXE_DM <= waddr_out_ID_EXE;
            memWrite_EXE_DM  <= r_memWrite_ID_EXE;
            memRead_EXE_DM   <= r_memRead_ID_EXE;
            memToReg_WB      <= r_memToReg_ID_EXE;
            wen_DM_WB        <= r_wen_ID_EXE;
            jal_out          <= r_jal_ID_EXE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (wen_DM_WB) begin
            r_regs[waddr_jal] <= res;
        end
    end

    // Data memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (rst && memWrite_EXE_DM) r_dmem[aluout_EXE_DM[7:0]] <= rdata2_EXE_DM;
    end
endmodule

// File: tb/tb_pipelined_regfile_3stage.sv
// Directed-program bench for pipelined_regfile_3stage: two ROM images, hand-computed expectations.
module tb_pipelined_regfile_3stage;
    localparam int W = 16;

    function automatic logic [256*W-1:0] build_img0();
        logic [256*W-1:0] v;
        v = '0;
        v[0*W +: W]     = 16'h6105; // ADDI r1,r0,5
        v[1*W +: W]     = 16'h0211; // ADD  r2,r1,r1
        v[2*W +: W]     = 16'h3410; // OR   r4,r1,r0
        v[4*W +: W]     = 16'h9002; // BEQ  r0,r0,+2
        v[5*W +: W]     = 16'h6501; // ADDI r5,r0,1 (squashed)
        v[6*W +: W]     = 16'h6601; // skipped
        v[7*W +: W]     = 16'h6703; // ADDI r7,r0,3
        v[10*W +: W]    = 16'hB020; // JAL  0x020
        v[11*W +: W]    = 16'h6801; // skipped
        v[32*W +: W]    = 16'h6107; // ADDI r1,r0,7
        v[33*W +: W]    = 16'h8103; // SW   r1,r0,3
        v[34*W +: W]    = 16'h7203; // LW   r2,r0,3
        v[35*W +: W]    = 16'h0322; // ADD  r3,r2,r2
        v[36*W +: W]    = 16'hA024; // J    0x024 (self loop)
        return v;
    endfunction

    function automatic logic [256*W-1:0] build_img1();
        logic [256*W-1:0] v;
        v = '0;
        v[0*W +: W] = 16'h6A0C; // ADDI r10,r0,-4
        v[1*W +: W] = 16'h5BA0; // SLT  r11,r10,r0
        v[2*W +: W] = 16'h1C0A; // SUB  r12,r0,r10
        v[3*W +: W] = 16'h1CCC; // SUB  r12,r12,r12
        return v;
    endfunction

    localparam logic [256*W-1:0] IMG0 = build_img0();
    localparam logic [256*W-1:0] IMG1 = build_img1();

    logic          clk = 1'b0;
    logic          rst, fileid;
    logic [W-1:0]  PCOUT, PCIN, INST, rdata1, rdata2;
    logic          regDst, jump;
    logic [W-1:0]  PC_ID_EXE, rdata1_ID_EXE, rdata2_ID_EXE, imm_ID_EXE;
    logic [2:0]    aluop_ID_EXE;
    logic          alusrc_ID_EXE, branch_ID_EXE, jr;
    logic [3:0]    waddr_out_ID_EXE;
    logic [W-1:0]  rdata2_imm_ID_EXE, aluout;
    logic          zero;
    logic [W-1:0]  aluout_EXE_DM, rdata2_EXE_DM;
    logic [3:0]    waddr_out_EXE_DM;
    logic          memWrite_EXE_DM, memRead_EXE_DM, memToReg_WB, wen_DM_WB, jal_out;
    logic [W-1:0]  readMem, aluout_DM, res, aluout_WB;
    logic [3:0]    waddr_jal;
    logic [W-1:0]  aluout_jal;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_regfile_3stage #(.ISIZE(W), .IMAGE0(IMG0), .IMAGE1(IMG1)) dut (
        .clk(clk), .rst(rst), .fileid(fileid),
        .PCOUT(PCOUT), .PCIN(PCIN), .INST(INST), .rdata1(rdata1), .rdata2(rdata2),
        .regDst(regDst), .jump(jump),
        .PC_ID_EXE(PC_ID_EXE), .rdata1_ID_EXE(rdata1_ID_EXE), .rdata2_ID_EXE(rdata2_ID_EXE),
        .imm_ID_EXE(imm_ID_EXE), .aluop_ID_EXE(aluop_ID_EXE), .alusrc_ID_EXE(alusrc_ID_EXE),
        .branch_ID_EXE(branch_ID_EXE), .jr(jr), .waddr_out_ID_EXE(waddr_out_ID_EXE),
        .rdata2_imm_ID_EXE(rdata2_imm_ID_EXE), .aluout(aluout), .zero(zero),
        .aluout_EXE_DM(aluout_EXE_DM), .rdata2_EXE_DM(rdata2_EXE_DM),
        .waddr_out_EXE_DM(waddr_out_EXE_DM), .memWrite_EXE_DM(memWrite_EXE_DM),
        .memRead_EXE_DM(memRead_EXE_DM), .memToReg_WB(memToReg_WB), .wen_DM_WB(wen_DM_WB),
        .jal_out(jal_out), .readMem(readMem), .aluout_DM(aluout_DM), .res(res),
        .aluout_WB(aluout_WB), .waddr_jal(waddr_jal), .aluout_jal(aluout_jal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        fileid = 1'b0;
        repeat (3) tick();
        chk("rst_pc", PCOUT, 0);
        chk("rst_wen", wen_DM_WB, 0);
        chk("rst_alu_exdm", aluout_EXE_DM, 0);
        chk("rst_res", res, 0);

        rst = 1'b1;
        chk("c0_inst", INST, 16'h6105);
        chk("c0_regdst", regDst, 1);
        chk("c0_pcin", PCIN, 1);
        tick(); // t1
        chk("t1_pc", PCOUT, 1);
        chk("t1_imm", imm_ID_EXE, 5);
        chk("t1_waddr_idex", waddr_out_ID_EXE, 1);
        chk("t1_aluout", aluout, 5);
        tick(); // t2
        chk("t2_pc", PCOUT, 2);
        chk("t2_res_addi", res, 5);
        chk("t2_waddr", waddr_jal, 1);
        chk("t2_fwd_add", aluout, 10);
        chk("t2_wthru", rdata1, 5);
        tick(); // t3
        chk("t3_pc", PCOUT, 3);
        chk("t3_res_add", res, 10);
        chk("t3_waddr", waddr_jal, 2);
        chk("t3_or", aluout, 5);
        tick(); // t4
        chk("t4_inst_beq", INST, 16'h9002);
        tick(); // t5
        chk("t5_branch", branch_ID_EXE, 1);
        chk("t5_zero", zero, 1);
        chk("t5_pcin_beq", PCIN, 7);
        tick(); // t6
        chk("t6_pc", PCOUT, 7);
        chk("t6_bubble", waddr_out_ID_EXE, 0);
        tick(); // t7
        chk("t7_squash_wen", wen_DM_WB, 0);
        chk("t7_addi7", aluout, 3);
        tick(); // t8
        chk("t8_res_r7", res, 3);
        chk("t8_waddr", waddr_jal, 7);
        tick(); // t9
        chk("t9_pc", PCOUT, 10);
        chk("t9_jump", jump, 1);
        chk("t9_pcin_jal", PCIN, 16'h0020);
        tick(); // t10
        chk("t10_pc", PCOUT, 16'h0020);
        chk("t10_jal_alu", aluout, 11);
        tick(); // t11
        chk("t11_waddr_jal", waddr_jal, 15);
        chk("t11_aluout_jal", aluout_jal, 11);
        chk("t11_jal_out", jal_out, 1);
        tick(); // t12
        chk("t12_sw_addr", aluout, 3);
        tick(); // t13
        chk("t13_memwrite", memWrite_EXE_DM, 1);
        chk("t13_sw_addr", aluout_EXE_DM, 3);
        chk("t13_sw_data", rdata2_EXE_DM, 7);
        tick(); // t14
        chk("t14_readmem", readMem, 7);
        chk("t14_memtoreg", memToReg_WB, 1);
        chk("t14_res_lw", res, 7);
        chk("t14_loaduse_fwd", aluout, 14);
        tick(); // t15
        chk("t15_res_r3", res, 14);
        chk("t15_waddr", waddr_jal, 3);
        chk("t15_pc_loop", PCOUT, 16'h0024);

        // Mid-flight reset with image1 selected
        rst = 1'b0;
        fileid = 1'b1;
        tick();
        chk("r2_pc", PCOUT, 0);
        chk("r2_wen", wen_DM_WB, 0);
        chk("r2_jal_out", jal_out, 0);
        chk("r2_inst_img1", INST, 16'h6A0C);
        rst = 1'b1;
        tick(); // t1
        chk("i1_addi_neg", aluout, 16'hFFFC);
        tick(); // t2
        chk("i1_slt", aluout, 1);
        chk("i1_wthru_rt", rdata2, 16'hFFFC);
        tick(); // t3
        chk("i1_sub", aluout, 4);
        chk("i1_nzero", zero, 0);
        tick(); // t4
        chk("i1_sub_self", aluout, 0);
        chk("i1_zero", zero, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
